// File: rtl/image_ctrl_pkg.sv
// Shared types and constants for the image sequencing controller.
package image_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHECK,
    S_RST_LD,
    S_LOAD,
    S_RST_FL,
    S_FILTER,
    S_RST_SV,
    S_SAVE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ZERO    = 2'd1;
  localparam logic [1:0] ERR_SIZE    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1 << 20;

endpackage

// File: rtl/phase_timer.sv
// Per-phase watchdog: counts active cycles and flags the last allowed cycle.
module phase_timer
  import image_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Count active cycles; hold at the last value so it never wraps back to zero.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = en && (count == LAST);

endmodule

// File: rtl/image_seq_ctrl.sv
// Frame sequencer: runs loader, filter and saver in order and owns the image RAM port.
//
// state    | meaning
// ---------+--------------------------------------------------
// IDLE     | waiting for start
// CHECK    | validate latched frame size
// RST_LD   | engine reset pulse before load
// LOAD     | loader owns the RAM port
// RST_FL   | engine reset pulse before filter
// FILTER   | noise filter owns the RAM port
// RST_SV   | engine reset pulse before save
// SAVE     | saver reads the RAM (no writes)
// DONE     | one-cycle completion pulse
// ERR      | latch error code, return to IDLE
module image_seq_ctrl
  import image_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [15:0]           M,
  input  logic [15:0]           N,
  input  logic                  loadF,
  input  logic                  filtF,
  input  logic                  saveF,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [ADDR_WIDTH-1:0] fl_addr,
  input  logic [ADDR_WIDTH-1:0] sv_addr,
  input  logic                  ld_we,
  input  logic                  fl_we,
  input  logic [DATA_WIDTH-1:0] ld_wdata,
  input  logic [DATA_WIDTH-1:0] fl_wdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  engRst,
  output logic                  loadEn,
  output logic                  filtEn,
  output logic                  saveEn,
  output logic [31:0]           dataCount,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            errCode
);

  // 33 bits so a full 2^32 capacity would still be representable.
  localparam logic [32:0] CAPACITY = 33'(1) << ADDR_WIDTH;

  state_t     state, next_state;
  logic [1:0] err_next;
  logic       in_phase;
  logic       expired;

  assign in_phase = (state == S_LOAD) || (state == S_FILTER) || (state == S_SAVE);

  // The timer is held cleared outside phases, so it restarts at zero on every phase entry.
  phase_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!in_phase),
    .en      (in_phase),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Frame size latch and sticky error flag/code.
  always_ff @(posedge clk) begin
    if (rst) begin
      dataCount <= '0;
      err       <= 1'b0;
      errCode   <= ERR_NONE;
    end else if ((state == S_IDLE) && start) begin
      dataCount <= 32'(M) * 32'(N);
      err       <= 1'b0;
      errCode   <= ERR_NONE;
    end else if ((next_state == S_ERR) && (state != S_ERR)) begin
      err       <= 1'b1;
      errCode   <= err_next;
    end
  end

  // Next-state logic, state decode and RAM port mux.
  always_comb begin
    next_state = state;
    err_next   = ERR_NONE;
    engRst     = 1'b0;
    loadEn     = 1'b0;
    filtEn     = 1'b0;
    saveEn     = 1'b0;
    done       = 1'b0;
    busy       = (state != S_IDLE);
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    case (state)
      S_IDLE:   if (start) next_state = S_CHECK;
      S_CHECK: begin
        if (dataCount == '0) begin
          next_state = S_ERR;
          err_next   = ERR_ZERO;
        end else if ({1'b0, dataCount} > CAPACITY) begin
          next_state = S_ERR;
          err_next   = ERR_SIZE;
        end else begin
          next_state = S_RST_LD;
        end
      end
      S_RST_LD: begin
        engRst     = 1'b1;
        next_state = S_LOAD;
      end
      S_LOAD: begin
        loadEn    = 1'b1;
        mem_addr  = ld_addr;
        mem_we    = ld_we;
        mem_wdata = ld_wdata;
        if (loadF) begin
          next_state = S_RST_FL;
        end else if (expired) begin
          next_state = S_ERR;
          err_next   = ERR_TIMEOUT;
        end
      end
      S_RST_FL: begin
        engRst     = 1'b1;
        next_state = S_FILTER;
      end
      S_FILTER: begin
        filtEn    = 1'b1;
        mem_addr  = fl_addr;
        mem_we    = fl_we;
        mem_wdata = fl_wdata;
        if (filtF) begin
          next_state = S_RST_SV;
        end else if (expired) begin
          next_state = S_ERR;
          err_next   = ERR_TIMEOUT;
        end
      end
      S_RST_SV: begin
        engRst     = 1'b1;
        next_state = S_SAVE;
      end
      S_SAVE: begin
        saveEn   = 1'b1;
        mem_addr = sv_addr;
        if (saveF) begin
          next_state = S_DONE;
        end else if (expired) begin
          next_state = S_ERR;
          err_next   = ERR_TIMEOUT;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      S_ERR:    next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_image_seq_ctrl.sv
// Directed bench for image_seq_ctrl with a small engine model driving the done flags.
module tb_image_seq_ctrl;

  localparam int DW = 8;
  localparam int AW = 16;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   M = '0, N = '0;
  logic          loadF = 1'b0, filtF = 1'b0, saveF = 1'b0;
  logic [AW-1:0] ld_addr = 16'h0012, fl_addr = 16'h0056, sv_addr = 16'h0034;
  logic          ld_we = 1'b1, fl_we = 1'b1;
  logic [DW-1:0] ld_wdata = 8'hA5, fl_wdata = 8'h5A;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic          engRst, loadEn, filtEn, saveEn, busy, done, err;
  logic [31:0]   dataCount;
  logic [1:0]    errCode;

  int vectors = 0;
  int miscompares = 0;

  // engine model knobs and per-frame observations
  int dl, df, ds;
  bit kick_in_filter, rst_in_save;
  int n_ld, n_fl, n_sv, n_rst, n_done, n_bad, done_cyc;
  logic [31:0] dc_in_save;

  image_seq_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .M(M), .N(N),
    .loadF(loadF), .filtF(filtF), .saveF(saveF),
    .ld_addr(ld_addr), .fl_addr(fl_addr), .sv_addr(sv_addr),
    .ld_we(ld_we), .fl_we(fl_we), .ld_wdata(ld_wdata), .fl_wdata(fl_wdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .engRst(engRst), .loadEn(loadEn), .filtEn(filtEn), .saveEn(saveEn),
    .dataCount(dataCount), .busy(busy), .done(done), .err(err), .errCode(errCode)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected RAM port given which engine is enabled (inputs are held constant).
  function automatic logic [31:0] exp_mux(input logic le, input logic fe, input logic se);
    if (le)      return 32'({16'h0012, 1'b1, 8'hA5});
    else if (fe) return 32'({16'h0056, 1'b1, 8'h5A});
    else if (se) return 32'({16'h0034, 1'b0, 8'h00});
    else         return 32'd0;
  endfunction

  // Issue one start and follow the frame until the controller is idle again.
  // Iteration 1 is the edge that accepts start.
  task automatic run_frame(input logic [15:0] m, input logic [15:0] n, input int budget);
    int cnt;
    bit kicked, resetted, finished;
    n_ld = 0; n_fl = 0; n_sv = 0; n_rst = 0; n_done = 0; n_bad = 0;
    done_cyc = -1; dc_in_save = '0;
    cnt = 0; kicked = 0; resetted = 0; finished = 0;
    M = m; N = n; start = 1'b1;
    for (int cyc = 1; cyc <= budget && !finished; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      rst = 1'b0;
      check_vec("mem_mux", 32'({mem_addr, mem_we, mem_wdata}), exp_mux(loadEn, filtEn, saveEn));
      if (engRst) begin
        n_rst++;
        cnt = 0;
        if (loadEn || filtEn || saveEn) n_bad++;
      end
      if (int'(loadEn) + int'(filtEn) + int'(saveEn) > 1) n_bad++;
      if (loadEn) begin
        n_ld++; cnt++;
        if (n_fl != 0 || n_sv != 0) n_bad++;
      end
      if (filtEn) begin
        n_fl++; cnt++;
        if (n_ld == 0 || n_sv != 0) n_bad++;
      end
      if (saveEn) begin
        n_sv++; cnt++;
        if (n_fl == 0) n_bad++;
        dc_in_save = dataCount;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      loadF = loadEn && (cnt >= dl);
      filtF = filtEn && (cnt >= df);
      saveF = saveEn && (cnt >= ds);
      if (filtEn && kick_in_filter && !kicked) begin
        start = 1'b1; M = 16'd7; N = 16'd7; kicked = 1;
      end
      if (saveEn && rst_in_save && !resetted) begin
        rst = 1'b1; resetted = 1;
      end
      if (!busy && !rst) finished = 1;
    end
    if (!finished) check_vec("frame_ends", 32'(busy), 32'd0);
    loadF = 1'b0; filtF = 1'b0; saveF = 1'b0; start = 1'b0; rst = 1'b0;
    kick_in_filter = 0; rst_in_save = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    kick_in_filter = 0; rst_in_save = 0;
    // reset values
    repeat (3) @(posedge clk);
    #1;
    check_vec("rst_busy",   32'(busy), 32'd0);
    check_vec("rst_done",   32'(done), 32'd0);
    check_vec("rst_err",    32'(err), 32'd0);
    check_vec("rst_code",   32'(errCode), 32'd0);
    check_vec("rst_count",  dataCount, 32'd0);
    check_vec("rst_en",     32'({engRst, loadEn, filtEn, saveEn}), 32'd0);
    check_vec("rst_mem",    32'({mem_addr, mem_we, mem_wdata}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // minimum latency: flags high on the first cycle of each phase
    dl = 1; df = 1; ds = 1;
    run_frame(16'd2, 16'd3, 40);
    check_vec("min_count",  dataCount, 32'd6);
    check_vec("min_done_cyc", 32'(done_cyc), 32'd8);
    check_vec("min_ndone",  32'(n_done), 32'd1);
    check_vec("min_nrst",   32'(n_rst), 32'd3);
    check_vec("min_err",    32'(err), 32'd0);

    // 4x4 frame, each engine finishes after 16 cycles
    dl = 16; df = 16; ds = 16;
    run_frame(16'd4, 16'd4, 200);
    check_vec("f44_count",  dataCount, 32'd16);
    check_vec("f44_nld",    32'(n_ld), 32'd16);
    check_vec("f44_nfl",    32'(n_fl), 32'd16);
    check_vec("f44_nsv",    32'(n_sv), 32'd16);
    check_vec("f44_nrst",   32'(n_rst), 32'd3);
    check_vec("f44_order",  32'(n_bad), 32'd0);
    check_vec("f44_ndone",  32'(n_done), 32'd1);
    check_vec("f44_done_cyc", 32'(done_cyc), 32'd53);
    check_vec("f44_err",    32'(err), 32'd0);

    // zero size
    dl = 1; df = 1; ds = 1;
    run_frame(16'd0, 16'd5, 40);
    check_vec("zero_err",   32'(err), 32'd1);
    check_vec("zero_code",  32'(errCode), 32'd1);
    check_vec("zero_en",    32'(n_ld + n_fl + n_sv + n_rst), 32'd0);
    check_vec("zero_ndone", 32'(n_done), 32'd0);

    // next valid start clears the error
    run_frame(16'd3, 16'd3, 40);
    check_vec("clr_err",    32'(err), 32'd0);
    check_vec("clr_code",   32'(errCode), 32'd0);
    check_vec("clr_count",  dataCount, 32'd9);
    check_vec("clr_ndone",  32'(n_done), 32'd1);

    // oversize frame
    run_frame(16'd300, 16'd300, 40);
    check_vec("big_count",  dataCount, 32'd90000);
    check_vec("big_err",    32'(err), 32'd1);
    check_vec("big_code",   32'(errCode), 32'd2);
    check_vec("big_en",     32'(n_ld + n_fl + n_sv), 32'd0);

    // exactly full RAM is accepted, one row more is not
    run_frame(16'd256, 16'd256, 40);
    check_vec("full_count", dataCount, 32'd65536);
    check_vec("full_ndone", 32'(n_done), 32'd1);
    check_vec("full_err",   32'(err), 32'd0);
    run_frame(16'd257, 16'd256, 40);
    check_vec("over_code",  32'(errCode), 32'd2);

    // filter never finishes: times out after 64 filter cycles
    dl = 1; df = 100000; ds = 1;
    run_frame(16'd4, 16'd4, 200);
    check_vec("to_nfl",     32'(n_fl), 32'd64);
    check_vec("to_nsv",     32'(n_sv), 32'd0);
    check_vec("to_err",     32'(err), 32'd1);
    check_vec("to_code",    32'(errCode), 32'd3);
    check_vec("to_ndone",   32'(n_done), 32'd0);

    // done flag on the timeout cycle wins
    dl = 1; df = 64; ds = 1;
    run_frame(16'd4, 16'd4, 200);
    check_vec("tie_nfl",    32'(n_fl), 32'd64);
    check_vec("tie_ndone",  32'(n_done), 32'd1);
    check_vec("tie_err",    32'(err), 32'd0);

    // start during FILTER is ignored, reset in SAVE aborts the frame
    dl = 3; df = 3; ds = 3;
    kick_in_filter = 1; rst_in_save = 1;
    run_frame(16'd4, 16'd4, 100);
    check_vec("abort_nfl",    32'(n_fl), 32'd3);
    check_vec("abort_cnt_sv", dc_in_save, 32'd16);
    check_vec("abort_ndone",  32'(n_done), 32'd0);
    check_vec("abort_busy",   32'(busy), 32'd0);
    check_vec("abort_en",     32'({engRst, loadEn, filtEn, saveEn, done}), 32'd0);
    check_vec("abort_count",  dataCount, 32'd0);
    check_vec("abort_err",    32'({err, errCode}), 32'd0);
    check_vec("abort_mem",    32'({mem_addr, mem_we, mem_wdata}), 32'd0);

    // controller restarts cleanly after the abort
    dl = 1; df = 1; ds = 1;
    run_frame(16'd1, 16'd1, 40);
    check_vec("post_ndone", 32'(n_done), 32'd1);
    check_vec("post_count", dataCount, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
